// File: rtl/aliens_bus_ctrl.sv
// Aliens CPU bus sequencer: address strobe, ROM wait states, bank and control latches.
// Define ALIENS_BUS_CTRL_READBACK_EN to make the control byte readable at CTRL_ADDR.
module aliens_bus_ctrl #(
    parameter int          WAIT_ROM  = 2,
    parameter logic [15:0] CTRL_ADDR = 16'h5F88
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    input  logic       lines_stb,
    input  logic [7:0] lines_data,
    output logic       as,
    output logic [5:0] ma,
    output logic       bk4,
    output logic       init,
    output logic       woco,
    output logic [3:0] prog_bank,
    output logic       cpu_ready,
    output logic [7:0] cpu_din
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    localparam logic [2:0] WAIT_CNT = (WAIT_ROM > 0) ? 3'(WAIT_ROM - 1) : 3'd0;

`ifdef ALIENS_BUS_CTRL_READBACK_EN
    localparam logic [7:0] KEEP = 8'hFF;
`else
    localparam logic [7:0] KEEP = 8'h60;
`endif

    state_t      state, state_nx;
    logic [2:0]  cnt_q, cnt_nx;
    logic [15:0] addr_q;
    logic        wr_q;
    logic [7:0]  dout_q;
    logic [4:0]  bank_q;
    logic [7:0]  ctrl_q;
    logic        rom_hit;
    logic        ctrl_hit;
    logic        ctrl_wr;

    assign rom_hit  = addr_q >= 16'h6000;
    assign ctrl_hit = addr_q == CTRL_ADDR;
    assign ctrl_wr  = (state == DONE) && wr_q && ctrl_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt_q <= 3'd0;
        end else begin
            state <= state_nx;
            cnt_q <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_q;
        unique case (state)
            IDLE: if (cpu_req) state_nx = ADDR;
            ADDR: begin
                if (rom_hit && (WAIT_ROM > 0)) begin
                    state_nx = WAIT;
                    cnt_nx   = WAIT_CNT;
                end else begin
                    state_nx = DONE;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) state_nx = DONE;
                else               cnt_nx   = cnt_q - 3'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request fields are captured only when a new bus cycle is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 16'h0000;
            wr_q   <= 1'b0;
            dout_q <= 8'h00;
        end else if ((state == IDLE) && cpu_req) begin
            addr_q <= cpu_addr;
            wr_q   <= cpu_wr;
            dout_q <= cpu_dout & KEEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            bank_q <= 5'd0;
        else if (lines_stb) bank_q <= lines_data[4:0];
    end

    always_ff @(posedge clk) begin
        if (rst)          ctrl_q <= 8'h00;
        else if (ctrl_wr) ctrl_q <= dout_q;
    end

    assign as        = state != IDLE;
    assign cpu_ready = state == DONE;
    assign ma        = addr_q[15:10];
    assign prog_bank = bank_q[3:0];
    assign bk4       = bank_q[4];
    assign init      = ctrl_q[6];
    assign woco      = ctrl_q[5];

`ifdef ALIENS_BUS_CTRL_READBACK_EN
    assign cpu_din = ((state == DONE) && !wr_q && ctrl_hit) ? ctrl_q : 8'h00;
`else
    assign cpu_din = 8'h00;
    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl_q[7], ctrl_q[4:0]};
`endif

    logic unused_lines;
    assign unused_lines = ^lines_data[7:5];

endmodule

// File: tb/tb_aliens_bus_ctrl.sv
// Bench for aliens_bus_ctrl: directed corner steps, then random accesses
// checked against a latency/register model.
module tb_aliens_bus_ctrl;

    localparam int          WAIT_ROM = 2;
    localparam logic [15:0] CTRL     = 16'h5F88;
`ifdef ALIENS_BUS_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        lines_stb;
    logic [7:0]  lines_data;
    logic        as;
    logic [5:0]  ma;
    logic        bk4;
    logic        init;
    logic        woco;
    logic [3:0]  prog_bank;
    logic        cpu_ready;
    logic [7:0]  cpu_din;

    aliens_bus_ctrl #(.WAIT_ROM(WAIT_ROM), .CTRL_ADDR(CTRL)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .lines_stb(lines_stb), .lines_data(lines_data),
        .as(as), .ma(ma), .bk4(bk4), .init(init), .woco(woco),
        .prog_bank(prog_bank), .cpu_ready(cpu_ready), .cpu_din(cpu_din)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int         rdy_at, rdy_n, as_n, ma_bad;
    logic [7:0] din_obs;
    logic [1:0] ctl_obs;
    logic [4:0] bank_obs;

    // model state
    logic [7:0] m_ctrl = 8'h00;
    logic [4:0] m_bank = 5'd0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [15:0] a);
        return (a >= 16'h6000) ? 2 + WAIT_ROM : 2;
    endfunction

    // Cycle 0 is the request cycle; stb_at/req2_at name the cycle
    // in which lines_stb / a second cpu_req are held high.
    task automatic access(input string tag, input logic wr,
                          input logic [15:0] a, input logic [7:0] d,
                          input int stb_at, input logic [7:0] sd,
                          input int req2_at);
        int lat;
        logic [7:0] exp_din;
        lat = exp_lat(a);
        exp_din = (RB && !wr && a == CTRL) ? m_ctrl : 8'h00;
        rdy_at = -1; rdy_n = 0; as_n = 0; ma_bad = 0;
        din_obs = 8'h00; ctl_obs = 2'b00; bank_obs = 5'd0;
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_dout = d;
        lines_data = sd; lines_stb = (stb_at == 0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            cpu_req = (c == req2_at);
            cpu_addr = ~a; cpu_wr = ~wr; cpu_dout = ~d;
            lines_stb = (c == stb_at);
            if (as) begin
                as_n++;
                if (ma !== a[15:10]) ma_bad++;
            end
            if (cpu_ready) begin
                rdy_n++;
                if (rdy_at < 0) begin
                    rdy_at = c;
                    din_obs = cpu_din;
                end
            end
            if (c == rdy_at + 1) ctl_obs = {init, woco};
            if (c == stb_at + 1) bank_obs = {bk4, prog_bank};
        end
        cpu_req = 1'b0;
        lines_stb = 1'b0;
        if (wr && a == CTRL) m_ctrl = d;
        if (stb_at >= 0) m_bank = sd[4:0];
        chk({tag, " latency"}, rdy_at, lat);
        chk({tag, " ready_pulses"}, rdy_n, 1);
        chk({tag, " as_cycles"}, as_n, lat);
        chk({tag, " ma_errors"}, ma_bad, 0);
        chk({tag, " cpu_din"}, din_obs, exp_din);
        chk({tag, " ctrl_after_ready"}, ctl_obs, {m_ctrl[6], m_ctrl[5]});
        if (stb_at >= 0) chk({tag, " bank_next_edge"}, bank_obs, sd[4:0]);
        chk({tag, " bank_final"}, {bk4, prog_bank}, m_bank);
    endtask

    initial begin
        int n_rdy;
        logic [15:0] ra;
        logic        rw;
        logic [7:0]  rd;
        int          rs, rq;

        rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0;
        cpu_dout = 8'h00; lines_stb = 1'b0; lines_data = 8'h00;
        tick();
        tick();
        chk("reset_outputs",
            {as, cpu_ready, bk4, init, woco, prog_bank, ma, cpu_din}, 0);
        rst = 1'b0;
        tick();

        access("rd_4000", 1'b0, 16'h4000, 8'h00, -1, 8'h00, -1);
        chk("rd_4000 ma_hold", ma, 6'b010000);
        access("rd_8000", 1'b0, 16'h8000, 8'h00, -1, 8'h00, -1);
        access("rd_5fff", 1'b0, 16'h5FFF, 8'h00, -1, 8'h00, -1);
        access("rd_6000", 1'b0, 16'h6000, 8'h00, -1, 8'h00, -1);
        access("wr_ctrl_60", 1'b1, CTRL, 8'h60, -1, 8'h00, -1);
        chk("wr_ctrl_60 init_woco", {init, woco}, 2'b11);
        access("rd_ctrl", 1'b0, CTRL, 8'h00, -1, 8'h00, -1);
        access("stb_in_wait", 1'b0, 16'h8000, 8'h00, 2, 8'h1A, -1);
        chk("stb_in_wait bank", {bk4, prog_bank}, 5'h1A);
        access("req_in_addr", 1'b0, 16'h1234, 8'h00, -1, 8'h00, 1);
        access("ctrl_and_stb", 1'b1, CTRL, 8'h20, 2, 8'h05, -1);

        // Reset in WAIT with outputs preloaded non-zero.
        access("preload", 1'b1, CTRL, 8'h60, 1, 8'h1F, -1);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h8000;
        tick();
        cpu_req = 1'b0;
        tick();
        chk("rst_wait as_before", as, 1'b1);
        chk("rst_wait ready_before", cpu_ready, 1'b0);
        rst = 1'b1; lines_stb = 1'b1; lines_data = 8'hFF; cpu_req = 1'b1;
        tick();
        chk("rst_wait outputs",
            {as, cpu_ready, bk4, init, woco, prog_bank, ma, cpu_din}, 0);
        rst = 1'b0; lines_stb = 1'b0; cpu_req = 1'b0;
        n_rdy = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (cpu_ready || as) n_rdy++;
        end
        chk("rst_wait no_ready", n_rdy, 0);
        m_ctrl = 8'h00;
        m_bank = 5'd0;

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? CTRL : 16'($urandom);
            rw = 1'($urandom);
            rd = 8'($urandom);
            rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            rq = ($urandom_range(0, 1) == 0) ?
                 int'($urandom_range(1, exp_lat(ra))) : -1;
            access($sformatf("rand%0d", i), rw, ra, rd, rs, 8'($urandom), rq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aliens_bus_ctrl.md
ALIENS_BUS_CTRL -- requirements
Module: aliens_bus_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_ROM, default 2, giving the wait states added to program-ROM accesses (legal range 0-7).
REQ-002 The block SHALL have parameter CTRL_ADDR, default 16'h5F88, giving the address of the control register.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; every register updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cpu_req, input, 1 bit: a one-cycle pulse that starts a bus cycle.
REQ-006 The block SHALL have port cpu_wr, input, 1 bit: 1 means write and 0 means read; sampled with cpu_req.
REQ-007 The block SHALL have port cpu_addr, input, 16 bits: the CPU address; sampled with cpu_req.
REQ-008 The block SHALL have port cpu_dout, input, 8 bits: the CPU write data; sampled with cpu_req.
REQ-009 The block SHALL have port lines_stb, input, 1 bit: strobe from the CPU bank-lines output.
REQ-010 The block SHALL have port lines_data, input, 8 bits: the bank-lines value.
REQ-011 The block SHALL have port as, output, 1 bit: address strobe to the address-decoder PAL.
REQ-012 The block SHALL have port ma, output, 6 bits: the latched cpu_addr[15:10] (MAF..MAA) to the decoder.
REQ-013 The block SHALL have port bk4, output, 1 bit: bank bit 4 to the decoder.
REQ-014 The block SHALL have port init, output, 1 bit: the INIT level to the decoder.
REQ-015 The block SHALL have port woco, output, 1 bit: the work-RAM/palette select to the decoder.
REQ-016 The block SHALL have port prog_bank, output, 4 bits: the banked program-ROM page.
REQ-017 The block SHALL have port cpu_ready, output, 1 bit: a one-cycle completion pulse.
REQ-018 The block SHALL have port cpu_din, output, 8 bits: read data (see Configuration).

Function
REQ-019 The block SHALL contain a state machine with the states IDLE, ADDR, WAIT and DONE.
REQ-020 IDLE SHALL move to ADDR on cpu_req=1 and latch cpu_addr, cpu_wr and cpu_dout.
REQ-021 ADDR SHALL move to WAIT when the latched address is in 0x6000-0xFFFF and WAIT_ROM>0; otherwise it SHALL move to DONE.
REQ-022 WAIT SHALL count down from WAIT_ROM-1 and move to DONE when the count is 0.
REQ-023 DONE SHALL move to IDLE unconditionally.
REQ-024 as SHALL be 1 in ADDR, WAIT and DONE, and 0 in IDLE.
REQ-025 ma SHALL hold the latched address bits throughout the cycle.
REQ-026 cpu_ready SHALL be 1 only in DONE.
REQ-027 Latency SHALL be 2 cycles from cpu_req to cpu_ready for non-ROM accesses and 2+WAIT_ROM cycles for ROM accesses.
REQ-028 A cpu_req arriving outside IDLE SHALL be ignored, with no queueing.
REQ-029 A write cycle whose latched address equals CTRL_ADDR SHALL update the control register on the DONE cycle, so the outputs change on the following edge: woco=dout[5], init=dout[6]; bits 7 and 4:0 are stored but drive no port.
REQ-030 lines_stb=1 SHALL load prog_bank=lines_data[3:0] and bk4=lines_data[4] on the next edge, independent of FSM state.
REQ-031 When lines_stb fires during a ROM cycle, the new bank SHALL be visible on the next edge; the in-flight cycle SHALL NOT be restarted.
REQ-032 When a control-register write completes in the same cycle as lines_stb, both updates SHALL apply.

Reset
REQ-033 While rst=1 the FSM SHALL go to IDLE, and on that edge as, cpu_ready, bk4, init, woco, prog_bank, ma, the wait counter and cpu_din SHALL all become 0.
REQ-034 rst=1 SHALL take priority over lines_stb, over cpu_req, and over a DONE-cycle register write.
REQ-035 A cycle interrupted by reset SHALL be abandoned with no cpu_ready pulse and no register update.

Configuration
REQ-036 With macro ALIENS_BUS_CTRL_READBACK_EN defined, a read cycle at CTRL_ADDR SHALL drive cpu_din with the stored control byte during DONE.
REQ-037 With ALIENS_BUS_CTRL_READBACK_EN defined, all other reads SHALL drive cpu_din with 8'h00.
REQ-038 Without ALIENS_BUS_CTRL_READBACK_EN, cpu_din SHALL be constant 8'h00 and the unused control bits SHALL not be stored.

Verification
REQ-039 The bench SHALL check: reset, then cpu_req read at 0x4000 -> as high for 2 cycles, cpu_ready pulse 2 cycles after req, ma=6'b010000.
REQ-040 The bench SHALL check: with WAIT_ROM=2, read at 0x8000 -> cpu_ready 4 cycles after req, as high for 4 cycles.
REQ-041 The bench SHALL check: write 8'h60 at 0x5F88 -> init=1 and woco=1 one edge after cpu_ready; with READBACK_EN, a subsequent read returns cpu_din=8'h60.
REQ-042 The bench SHALL check: lines_stb with lines_data=8'h1A during a WAIT state -> prog_bank=4'hA and bk4=1 next edge, and cpu_ready timing unchanged.
REQ-043 The bench SHALL check: rst in the WAIT state -> no cpu_ready, and all outputs 0 next edge.
REQ-044 The bench SHALL check: a second cpu_req during ADDR -> ignored, and exactly one cpu_ready pulse.
